// File: rtl/addsub_acc_ctrl_pkg.sv
// Shared definitions for the add/sub accumulator controller:
// command op codes, FSM state encodings and FLAGS bit positions.
package addsub_acc_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10,
    S_RESP = 2'b11
  } state_e;

  // FLAGS = {C,V,N,Z}
  localparam int FL_C = 3;
  localparam int FL_V = 2;
  localparam int FL_N = 1;
  localparam int FL_Z = 0;

endpackage

// File: rtl/addsub_acc_ctrl.sv
// addsub_acc_ctrl: command-driven accumulator around an external
// combinational add/sub datapath (sibling instance, wired via ADD_*).
// One command in flight: IDLE -> EXEC -> WB -> RESP -> IDLE.
// Optional build macro SATURATE_EN: on signed overflow the ADD/SUB result
// clamps to the most positive/negative value instead of wrapping.
module addsub_acc_ctrl
  import addsub_acc_ctrl_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] OPERAND,
  output logic [WIDTH-1:0] ADD_A,
  output logic [WIDTH-1:0] ADD_B,
  output logic             ADD_SEL,
  input  logic [WIDTH-1:0] ADD_SUM,
  input  logic             ADD_COUT,
  output logic [WIDTH-1:0] ACC,
  output logic [3:0]       FLAGS,
  output logic             OUT_VALID,
  input  logic             OUT_READY
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;
  logic             ovld_q, ovld_d;
  logic             rdy_q, rdy_d;
  logic             drive;

  // New accumulator value and {C,V,N,Z} for the command being written back.
  function automatic logic [WIDTH+3:0] wb_result(
    input op_e              op,
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] opnd,
    input logic [WIDTH-1:0] sum,
    input logic             cout
  );
    logic [WIDTH-1:0] res;
    logic [3:0]       fl;
    logic             sel;
    logic             v;
    res = acc;
    fl  = '0;
    sel = (op == OP_SUB);
    v   = 1'b0;
    case (op)
      OP_LOAD: res = opnd;
      OP_ADD, OP_SUB: begin
        // Overflow: operands (B as seen by the adder) share a sign and
        // the sum's sign differs from it.
        v   = (acc[WIDTH-1] == (opnd[WIDTH-1] ^ sel)) &&
              (sum[WIDTH-1] != acc[WIDTH-1]);
        res = sum;
`ifdef SATURATE_EN
        // The true result's sign is the accumulator's sign on overflow.
        if (v) res = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        fl[FL_C] = cout;
        fl[FL_V] = v;
      end
      default: res = ACC_INIT;
    endcase
    // CLR reports only Z; other ops take N from the result MSB.
    fl[FL_N] = (op != OP_CLR) && res[WIDTH-1];
    fl[FL_Z] = (res == '0);
    return {res, fl};
  endfunction

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      opnd_q  <= '0;
      acc_q   <= ACC_INIT;
      flags_q <= '0;
      ovld_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      ovld_q  <= ovld_d;
      rdy_q   <= rdy_d;
    end
  end

  // Next-state: accept in IDLE, let the adder settle in EXEC, capture in WB,
  // hold the response in RESP until consumed.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    ovld_d  = ovld_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID && rdy_q) begin
          op_d    = op_e'(OP);
          opnd_d  = OPERAND;
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        {acc_d, flags_d} = wb_result(op_q, acc_q, opnd_q, ADD_SUM, ADD_COUT);
        ovld_d  = 1'b1;
        state_d = S_RESP;
      end
      default: begin
        if (OUT_READY) begin
          ovld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
    // Registered ready keeps IN_READY low through reset and only high in IDLE.
    rdy_d = (state_d == S_IDLE);
  end

  // Adder inputs are live only while the command is in EXEC/WB.
  assign drive     = (state_q == S_EXEC) || (state_q == S_WB);
  assign ADD_A     = drive ? acc_q  : '0;
  assign ADD_B     = drive ? opnd_q : '0;
  assign ADD_SEL   = drive && (op_q == OP_SUB);
  assign ACC       = acc_q;
  assign FLAGS     = flags_q;
  assign OUT_VALID = ovld_q;
  assign IN_READY  = rdy_q;

endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Directed bench for addsub_acc_ctrl; the sibling 4-bit add/sub datapath
// is modelled here as a continuous assignment.
module tb_addsub_acc_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       IN_VALID;
  logic       IN_READY;
  logic [1:0] OP;
  logic [3:0] OPERAND;
  logic [3:0] ADD_A, ADD_B, ADD_SUM;
  logic       ADD_SEL, ADD_COUT;
  logic [3:0] ACC;
  logic [3:0] FLAGS;
  logic       OUT_VALID;
  logic       OUT_READY;

  int nvec = 0;
  int nerr = 0;
  int naccept = 0;
  logic [3:0] acc_m = 4'h0;

  always #5 CLK = ~CLK;

  // Adder: A + B, or A + ~B + 1 when subtracting; C_OUT = carry (1 = no borrow).
  assign {ADD_COUT, ADD_SUM} = {1'b0, ADD_A} + {1'b0, (ADD_SEL ? ~ADD_B : ADD_B)} + {4'b0, ADD_SEL};

  addsub_acc_ctrl #(.WIDTH(4), .ACC_INIT(4'h0)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OP(OP), .OPERAND(OPERAND),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_SEL(ADD_SEL),
    .ADD_SUM(ADD_SUM), .ADD_COUT(ADD_COUT),
    .ACC(ACC), .FLAGS(FLAGS),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
  );

  always @(posedge CLK) if (IN_VALID && IN_READY) naccept++;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command and return at the negedge after the accept edge (EXEC).
  task automatic send(input logic [1:0] op, input logic [3:0] b, input bit keep);
    int n = 0;
    IN_VALID = 1'b1; OP = op; OPERAND = b;
    while (!IN_READY && n < 20) begin @(negedge CLK); n++; end
    if (n >= 20) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: IN_READY %0b after %0d cycles, required 1", IN_READY, n);
    end
    @(negedge CLK);
    if (!keep) IN_VALID = 1'b0;
  endtask

  task automatic cmd(input string tag, input logic [1:0] op, input logic [3:0] b,
                     input logic [3:0] exp_acc, input logic [3:0] exp_fl, input bit keep);
    send(op, b, keep);
    chk({tag, "_exec_a"},   {4'h0, ADD_A}, {4'h0, acc_m});
    chk({tag, "_exec_b"},   {4'h0, ADD_B}, {4'h0, b});
    chk({tag, "_exec_sel"}, {7'h0, ADD_SEL}, {7'h0, (op == 2'b10)});
    chk({tag, "_vld_c0"},   {7'h0, OUT_VALID}, 8'h0);
    @(negedge CLK);
    chk({tag, "_wb_sel"},   {7'h0, ADD_SEL}, {7'h0, (op == 2'b10)});
    chk({tag, "_vld_c1"},   {7'h0, OUT_VALID}, 8'h0);
    @(negedge CLK);
    chk({tag, "_vld_c2"},   {7'h0, OUT_VALID}, 8'h1);
    chk({tag, "_acc"},      {4'h0, ACC}, {4'h0, exp_acc});
    chk({tag, "_flags"},    {4'h0, FLAGS}, {4'h0, exp_fl});
    chk({tag, "_rdy_resp"}, {7'h0, IN_READY}, 8'h0);
    chk({tag, "_sel_idle"}, {7'h0, ADD_SEL}, 8'h0);
    acc_m = exp_acc;
    if (OUT_READY) begin
      @(negedge CLK);
      chk({tag, "_vld_drop"}, {7'h0, OUT_VALID}, 8'h0);
    end
  endtask

  initial begin
    int acc0;
    RST_N = 1'b0; IN_VALID = 1'b0; OP = 2'b00; OPERAND = 4'h0; OUT_READY = 1'b1;
    @(negedge CLK); @(negedge CLK);
    chk("rst_acc",   {4'h0, ACC}, 8'h0);
    chk("rst_flags", {4'h0, FLAGS}, 8'h0);
    chk("rst_vld",   {7'h0, OUT_VALID}, 8'h0);
    chk("rst_rdy",   {7'h0, IN_READY}, 8'h0);
    chk("rst_sel",   {7'h0, ADD_SEL}, 8'h0);
    chk("rst_a",     {4'h0, ADD_A}, 8'h0);
    RST_N = 1'b1;

    // 1-2: load then subtract without borrow
    cmd("load4", 2'b00, 4'h4, 4'h4, 4'b0000, 1'b0);
    cmd("sub2",  2'b10, 4'h2, 4'h2, 4'b1000, 1'b0);
    // 3: signed overflow 7+1
    cmd("load7", 2'b00, 4'h7, 4'h7, 4'b0000, 1'b0);
`ifdef SATURATE_EN
    cmd("add1_ovf", 2'b01, 4'h1, 4'h7, 4'b0100, 1'b0);
`else
    cmd("add1_ovf", 2'b01, 4'h1, 4'h8, 4'b0110, 1'b0);
`endif
    // 4: unsigned wrap both directions
    cmd("loadF",  2'b00, 4'hF, 4'hF, 4'b0010, 1'b0);
    cmd("add1_wrap", 2'b01, 4'h1, 4'h0, 4'b1001, 1'b0);
    cmd("sub1_wrap", 2'b10, 4'h1, 4'hF, 4'b0010, 1'b0);
    cmd("clr",    2'b11, 4'h5, 4'h0, 4'b0001, 1'b0);
    cmd("load0",  2'b00, 4'h0, 4'h0, 4'b0001, 1'b0);

    // 5: response back-pressure with a second command waiting
    OUT_READY = 1'b0;
    cmd("bp_add3", 2'b01, 4'h3, 4'h3, 4'b0000, 1'b1);
    acc0 = naccept;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_vld_hold", {7'h0, OUT_VALID}, 8'h1);
      chk("bp_acc_hold", {4'h0, ACC}, 8'h3);
      chk("bp_rdy_low",  {7'h0, IN_READY}, 8'h0);
    end
    chk("bp_no_accept", naccept[7:0], acc0[7:0]);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    @(negedge CLK);
    chk("bp_release", {7'h0, OUT_VALID}, 8'h0);

    // 6: reset during EXEC aborts the command
    send(2'b00, 4'h9, 1'b0);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_acc", {4'h0, ACC}, 8'h0);
    chk("mid_rst_vld", {7'h0, OUT_VALID}, 8'h0);
    chk("mid_rst_rdy", {7'h0, IN_READY}, 8'h0);
    chk("mid_rst_sel", {7'h0, ADD_SEL}, 8'h0);
    @(negedge CLK); @(negedge CLK);
    RST_N = 1'b1;
    acc_m = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_vld", {7'h0, OUT_VALID}, 8'h0);
    end
    chk("post_rst_rdy", {7'h0, IN_READY}, 8'h1);
    chk("post_rst_acc", {4'h0, ACC}, 8'h0);
    cmd("loadA", 2'b00, 4'hA, 4'hA, 4'b0010, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
